// File: rtl/hamming_pkg.sv
// ---------------------------------------------------------------------------
// hamming_pkg
// Shared definitions for the [7,4] Hamming encoder/decoder pair.
//   - Codeword/data/syndrome widths.
//   - Hamming position numbers (1-based). Codeword bit index = position - 1.
//   - syndrome_t typedef.
//   - flip_mask(): one-hot mask selecting the codeword bit named by a syndrome.
//   - encode(): reference parity generation used by hamming_encoder.
// ---------------------------------------------------------------------------
package hamming_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 7;
  localparam int SYN_W  = 3;

  // Hamming positions (1-based): parity bits sit at the powers of two.
  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_D1 = 3;
  localparam int POS_P4 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;
  localparam int POS_D4 = 7;

  typedef logic [SYN_W-1:0] syndrome_t;

  // A nonzero syndrome names the erroneous position directly, so the mask
  // has a single bit set at index syndrome-1. A zero syndrome gives no flip.
  function automatic logic [CODE_W-1:0] flip_mask(input syndrome_t syn);
    logic [CODE_W-1:0] mask;
    mask = '0;
    for (int i = 1; i <= CODE_W; i++) begin
      if (syn == syndrome_t'(i)) mask[i-1] = 1'b1;
    end
    return mask;
  endfunction

  // Data {d4,d3,d2,d1} to codeword, bit i = Hamming position i+1.
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    c[POS_D1-1] = d[0];
    c[POS_D2-1] = d[1];
    c[POS_D3-1] = d[2];
    c[POS_D4-1] = d[3];
    c[POS_P1-1] = d[0] ^ d[1] ^ d[3];
    c[POS_P2-1] = d[0] ^ d[2] ^ d[3];
    c[POS_P4-1] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// ---------------------------------------------------------------------------
// hamming_syndrome
// Purely combinational syndrome calculator for a [7,4] Hamming codeword.
// Ports:
//   codeword  in   [6:0]  received word, bit i = Hamming position i+1
//   syndrome  out  [2:0]  {s4,s2,s1}; value is the erroneous position, 0 = clean
// ---------------------------------------------------------------------------
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] codeword,
  output logic [SYN_W-1:0]  syndrome
);

  // Each syndrome bit checks the positions whose index has that bit set.
  assign syndrome[0] = codeword[POS_P1-1] ^ codeword[POS_D1-1] ^
                       codeword[POS_D2-1] ^ codeword[POS_D4-1];
  assign syndrome[1] = codeword[POS_P2-1] ^ codeword[POS_D1-1] ^
                       codeword[POS_D3-1] ^ codeword[POS_D4-1];
  assign syndrome[2] = codeword[POS_P4-1] ^ codeword[POS_D2-1] ^
                       codeword[POS_D3-1] ^ codeword[POS_D4-1];

endmodule

// File: rtl/hamming_decoder.sv
// ---------------------------------------------------------------------------
// hamming_decoder
// Two-stage pipelined [7,4] Hamming single-error-correcting decoder with
// valid/ready handshakes on both sides.
//   S1: registers the incoming codeword and its syndrome.
//   S2: registers corrected data, syndrome and the corrected flag.
// Double-bit errors are indistinguishable from single errors in [7,4] and are
// miscorrected by design.
//
// Optional feature macro: HAMMING_ERR_CNT_EN
//   When defined, adds err_cnt/cnt_clr: a saturating count of output words
//   that carried a correction, with cnt_clr taking priority over increment.
//
// Ports:
//   clk        in          sole clock, rising edge
//   rst_n      in          asynchronous active-low reset
//   in_valid   in          codeword present
//   in_ready   out         decoder accepts codeword this cycle
//   codeword   in   [6:0]  received codeword, bit i = Hamming position i+1
//   out_valid  out         decoded result present
//   out_ready  in          downstream accepts result this cycle
//   data       out  [3:0]  corrected data {d4,d3,d2,d1}
//   syndrome   out  [2:0]  computed syndrome {s4,s2,s1}
//   corrected  out         syndrome was nonzero, one bit flipped
//   err_cnt    out  [CNT_W-1:0]  (HAMMING_ERR_CNT_EN only)
//   cnt_clr    in          (HAMMING_ERR_CNT_EN only) synchronous clear
// ---------------------------------------------------------------------------
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] codeword,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data,
  output logic [SYN_W-1:0]  syndrome,
  output logic              corrected
`ifdef HAMMING_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              cnt_clr
`endif
);

  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  syndrome_t         s1_syn;
  syndrome_t         syn_comb;
  logic              s2_advance;
  logic [CODE_W-1:0] fixed_code;
  logic [2:0]        unused_parity;

  hamming_syndrome u_syndrome (
    .codeword (codeword),
    .syndrome (syn_comb)
  );

  // Output stage moves when it is empty or its word is being taken.
  // S1 can take a new word when it is empty or its word moves into S2.
  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= codeword;
        s1_syn  <= syn_comb;
      end
    end
  end

  assign fixed_code = s1_code ^ flip_mask(s1_syn);

  // Parity positions are only consumed by the syndrome, which is already
  // captured in S1, so the corrected parity bits go nowhere.
  assign unused_parity = {fixed_code[POS_P4-1], fixed_code[POS_P2-1],
                          fixed_code[POS_P1-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data      <= '0;
      syndrome  <= '0;
      corrected <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data      <= {fixed_code[POS_D4-1], fixed_code[POS_D3-1],
                      fixed_code[POS_D2-1], fixed_code[POS_D1-1]};
        syndrome  <= s1_syn;
        corrected <= (s1_syn != '0);
      end
    end
  end

`ifdef HAMMING_ERR_CNT_EN
  // Counts corrected words as they leave the decoder; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && corrected && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// ---------------------------------------------------------------------------
// tb_hamming_decoder
// Directed self-checking bench for hamming_decoder. Define HAMMING_ERR_CNT_EN
// to also exercise the corrected-word counter (adds a CNT_W=2 instance).
// ---------------------------------------------------------------------------
module tb_hamming_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] codeword;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] data;
  logic [2:0] syndrome;
  logic       corrected;

  int checks = 0;
  int fails  = 0;

`ifdef HAMMING_ERR_CNT_EN
  logic [15:0] err_cnt;
  logic        cnt_clr;
  logic        in_ready2;
  logic        out_valid2;
  logic [3:0]  data2;
  logic [2:0]  syndrome2;
  logic        corrected2;
  logic [1:0]  err_cnt2;
  logic        cnt_clr2;
`endif

  always #5 clk = ~clk;

  hamming_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .codeword  (codeword),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data      (data),
    .syndrome  (syndrome),
    .corrected (corrected)
`ifdef HAMMING_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt),
    .cnt_clr   (cnt_clr)
`endif
  );

`ifdef HAMMING_ERR_CNT_EN
  hamming_decoder #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .codeword  (codeword),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .data      (data2),
    .syndrome  (syndrome2),
    .corrected (corrected2),
    .err_cnt   (err_cnt2),
    .cnt_clr   (cnt_clr2)
  );
`endif

  // Independent encoder: bit i = Hamming position i+1.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    codeword  = '0;
    out_ready = 1'b1;
`ifdef HAMMING_ERR_CNT_EN
    cnt_clr  = 1'b0;
    cnt_clr2 = 1'b0;
`endif
    #12;
    checks++;
    if ({out_valid, data, syndrome, corrected} !== 9'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %b expected 000000000",
               {out_valid, data, syndrome, corrected});
    end
`ifdef HAMMING_ERR_CNT_EN
    checks++;
    if (err_cnt !== 16'd0) begin
      fails++;
      $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt);
    end
`endif
    step();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  // One word at a time: result must appear exactly two edges after accept.
  task automatic test_clean_words();
    logic [6:0] words [3];
    logic [3:0] exp_d [3];
    words[0] = 7'b0000000; exp_d[0] = 4'b0000;
    words[1] = 7'b0011110; exp_d[1] = 4'b0011;
    words[2] = 7'b1111111; exp_d[2] = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      codeword = words[i];
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL clean_early[%0d]: got out_valid %b expected 0", i, out_valid);
      end
      step();
      checks++;
      if ({out_valid, data, syndrome, corrected} !== {1'b1, exp_d[i], 3'd0, 1'b0}) begin
        fails++;
        $display("[TB] FAIL clean_word[%0d]: got v=%b d=%b s=%0d c=%b expected v=1 d=%b s=0 c=0",
                 i, out_valid, data, syndrome, corrected, exp_d[i]);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL clean_drain[%0d]: got out_valid %b expected 0", i, out_valid);
      end
    end
  endtask

  // Row 2 is a double error (pos1+pos2 on 0011): syndrome 3 miscorrects d1.
  task automatic test_error_words();
    logic [6:0] words [3];
    logic [3:0] exp_d [3];
    logic [2:0] exp_s [3];
    words[0] = 7'b0001110; exp_d[0] = 4'b0011; exp_s[0] = 3'd5;
    words[1] = 7'b0000001; exp_d[1] = 4'b0000; exp_s[1] = 3'd1;
    words[2] = 7'b0011101; exp_d[2] = 4'b0010; exp_s[2] = 3'd3;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      codeword = words[i];
      step();
      in_valid = 1'b0;
      step();
      checks++;
      if ({out_valid, data, syndrome, corrected} !== {1'b1, exp_d[i], exp_s[i], 1'b1}) begin
        fails++;
        $display("[TB] FAIL error_word[%0d]: got v=%b d=%b s=%0d c=%b expected v=1 d=%b s=%0d c=1",
                 i, out_valid, data, syndrome, corrected, exp_d[i], exp_s[i]);
      end
      step();
    end
  endtask

  // All 16 data values x (clean + 7 single flips), streamed one per cycle.
  task automatic test_exhaustive();
    logic [3:0] q_d [$];
    logic [2:0] q_s [$];
    logic [3:0] ed;
    logic [2:0] es;
    int idx    = 0;
    int recv   = 0;
    int stalls = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 140; cyc++) begin
      if (out_valid === 1'b1) begin
        if (q_d.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL exh_extra: got unexpected word d=%b expected none", data);
        end else begin
          ed = q_d.pop_front();
          es = q_s.pop_front();
          checks++;
          if ({data, syndrome, corrected} !== {ed, es, (es != 3'd0)}) begin
            fails++;
            $display("[TB] FAIL exh_word[%0d]: got d=%b s=%0d c=%b expected d=%b s=%0d c=%b",
                     recv, data, syndrome, corrected, ed, es, (es != 3'd0));
          end
          recv++;
        end
      end
      if (idx < 128) begin
        in_valid = 1'b1;
        es = 3'(idx % 8);
        codeword = enc(4'(idx / 8)) ^ ((es == 3'd0) ? 7'd0 : (7'd1 << (es - 3'd1)));
        #1;
        if (in_ready === 1'b1) begin
          q_d.push_back(4'(idx / 8));
          q_s.push_back(es);
          idx++;
        end else begin
          stalls++;
        end
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (recv !== 128 || stalls !== 0) begin
      fails++;
      $display("[TB] FAIL exh_count: got %0d words %0d stalls expected 128 words 0 stalls",
               recv, stalls);
    end
  endtask

  // Four words; out_ready low in cycles 2..4 forces a full-pipeline stall.
  task automatic test_back_to_back();
    logic [6:0] words [4];
    logic [3:0] exp_d [4];
    logic [3:0] hold_d;
    logic [2:0] hold_s;
    logic       hold_c;
    logic       was_stalled = 1'b0;
    int sent = 0;
    int recv = 0;
    words[0] = enc(4'h1);              exp_d[0] = 4'h1;
    words[1] = enc(4'h6) ^ 7'b1000000; exp_d[1] = 4'h6;
    words[2] = enc(4'h9);              exp_d[2] = 4'h9;
    words[3] = enc(4'hE) ^ 7'b0000100; exp_d[3] = 4'hE;
    for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
      if (was_stalled) begin
        checks++;
        if ({out_valid, data, syndrome, corrected} !== {1'b1, hold_d, hold_s, hold_c}) begin
          fails++;
          $display("[TB] FAIL b2b_hold[%0d]: got v=%b d=%b s=%0d c=%b expected v=1 d=%b s=%0d c=%b",
                   cyc, out_valid, data, syndrome, corrected, hold_d, hold_s, hold_c);
        end
      end
      out_ready = !(cyc >= 2 && cyc < 5);
      in_valid  = (sent < 4);
      codeword  = words[sent < 4 ? sent : 3];
      #1;
      if (cyc == 2) begin
        checks++;
        if (in_ready !== 1'b0 || sent !== 2) begin
          fails++;
          $display("[TB] FAIL b2b_backpressure: got in_ready=%b accepted=%0d expected in_ready=0 accepted=2",
                   in_ready, sent);
        end
      end
      if (in_valid && in_ready === 1'b1) sent++;
      was_stalled = (out_valid === 1'b1) && !out_ready;
      hold_d = data;
      hold_s = syndrome;
      hold_c = corrected;
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (data !== exp_d[recv]) begin
          fails++;
          $display("[TB] FAIL b2b_order[%0d]: got %h expected %h", recv, data, exp_d[recv]);
        end
        recv++;
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv !== 4) begin
      fails++;
      $display("[TB] FAIL b2b_count: got %0d words expected 4", recv);
    end
  endtask

  task automatic test_reset_in_flight();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    codeword  = enc(4'h5);
    step();
    codeword  = enc(4'hA);
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rif_setup: got out_valid %b expected 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, data, syndrome, corrected} !== 9'b0) begin
      fails++;
      $display("[TB] FAIL rif_async_clear: got %b expected 000000000",
               {out_valid, data, syndrome, corrected});
    end
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rif_in_ready: got %b expected 1", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL rif_stale[%0d]: got out_valid %b expected 0", i, out_valid);
      end
    end
  endtask

`ifdef HAMMING_ERR_CNT_EN
  task automatic test_err_cnt();
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    cnt_clr2  = 1'b1;
    step();
    cnt_clr  = 1'b0;
    cnt_clr2 = 1'b0;
    checks++;
    if (err_cnt !== 16'd0 || err_cnt2 !== 2'd0) begin
      fails++;
      $display("[TB] FAIL cnt_clear: got %0d/%0d expected 0/0", err_cnt, err_cnt2);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      codeword = enc(4'(i + 3)) ^ (7'd1 << i);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (err_cnt !== 16'd3 || err_cnt2 !== 2'd3) begin
      fails++;
      $display("[TB] FAIL cnt_three: got %0d/%0d expected 3/3", err_cnt, err_cnt2);
    end
    // Fourth error: clear lands on the same edge as its output transfer.
    in_valid = 1'b1;
    codeword = enc(4'h7) ^ 7'b0100000;
    step();
    in_valid = 1'b0;
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (err_cnt !== 16'd0 || err_cnt2 !== 2'd3) begin
      fails++;
      $display("[TB] FAIL cnt_clr_wins: got %0d/%0d expected 0/3", err_cnt, err_cnt2);
    end
    in_valid = 1'b1;
    codeword = enc(4'h2) ^ 7'b0001000;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (err_cnt !== 16'd1 || err_cnt2 !== 2'd3) begin
      fails++;
      $display("[TB] FAIL cnt_saturate: got %0d/%0d expected 1/3", err_cnt, err_cnt2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_words();
    test_error_words();
    test_exhaustive();
    test_back_to_back();
    test_reset_in_flight();
`ifdef HAMMING_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
